dual_port_data_memory: RTL

DUAL_PORT_DATA_MEMORY -- requirements
Module: dual_port_data_memory

---
 rtl/dual_port_data_memory.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dual_port_data_memory.sv
// Dual-port word memory with a power-up clearing sequence.
// After reset the block walks every address writing zero (INIT), then
// serves two independent read/write ports with 1-cycle registered reads,
// write-first forwarding, and per-port out-of-range strobes (RUN).
module dual_port_data_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] data_bus_write0,
  input  logic [DATA_WIDTH-1:0] data_bus_write1,
  input  logic                  write0,
  input  logic                  write1,
  input  logic                  read0,
  input  logic                  read1,
  output logic [DATA_WIDTH-1:0] data_bus_read0,
  output logic [DATA_WIDTH-1:0] data_bus_read1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  addr_err0,
  output logic                  addr_err1,
  output logic                  ready
);

  localparam int                CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run;
  logic                    in0, in1;
  logic                    we0, we1;
  logic [CNT_W-1:0]        idx0, idx1;
  logic [DATA_WIDTH-1:0]   fwd0, fwd1;

  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                    rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                    err0_q, err0_d, err1_q, err1_d;

  // Range check on the full address: high bits never alias into the array.
  assign run  = (state_q == RUN);
  assign in0  = ({1'b0, address0} < DEPTH_A);
  assign in1  = ({1'b0, address1} < DEPTH_A);
  assign we0  = run & write0 & in0;
  assign we1  = run & write1 & in1;
  assign idx0 = address0[CNT_W-1:0];
  assign idx1 = address1[CNT_W-1:0];

  // FSM state and clear-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: walk the array once, then stay in RUN until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST) begin
        state_d    = RUN;
        init_cnt_d = '0;
      end
    end
  end

  // Storage: clearing in INIT, port writes in RUN. Port 1 is written last
  // so it wins a same-address collision. Reset never touches contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem[init_cnt_q] <= '0;
      end else begin
        if (we0) mem[idx0] <= data_bus_write0;
        if (we1) mem[idx1] <= data_bus_write1;
      end
    end
  end

  // Write-first read data: a same-cycle write to the read address is
  // returned instead of the stored word, port 1 taking priority.
  always_comb begin
    fwd0 = '0;
    fwd1 = '0;
    if (in0) begin
      if (we1 && address1 == address0) fwd0 = data_bus_write1;
      else if (we0)                    fwd0 = data_bus_write0;
      else                             fwd0 = mem[idx0];
    end
    if (in1) begin
      if (we1)                                fwd1 = data_bus_write1;
      else if (we0 && address0 == address1)   fwd1 = data_bus_write0;
      else                                    fwd1 = mem[idx1];
    end
  end

  // Next values for the read-side output registers; data holds when idle.
  always_comb begin
    rvalid0_d = run & read0;
    rvalid1_d = run & read1;
    err0_d    = run & (read0 | write0) & ~in0;
    err1_d    = run & (read1 | write1) & ~in1;
    rdata0_d  = rvalid0_d ? fwd0 : rdata0_q;
    rdata1_d  = rvalid1_d ? fwd1 : rdata1_q;
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  assign data_bus_read0 = rdata0_q;
  assign data_bus_read1 = rdata1_q;
  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign addr_err0      = err0_q;
  assign addr_err1      = err1_q;
  assign ready          = run;

endmodule
